// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared hazard class codes and FSM state encoding for the ID-stage stall controller.
package hazard_stall_ctrl_pkg;

    localparam int NB_HAZ_TYPE = 2;

    typedef enum logic [NB_HAZ_TYPE-1:0] {
        HAZ_NONE    = 2'd0,
        HAZ_LOADUSE = 2'd1,
        HAZ_BRALU   = 2'd2,
        HAZ_BRLOAD  = 2'd3
    } haz_type_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Comparator slots: {MEM load, EX write, EX load} x {rt, rs}
    localparam int NUM_CMP    = 6;
    localparam int CMP_EXLD   = 0;
    localparam int CMP_EXWE   = 2;
    localparam int CMP_MEMLD  = 4;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage operand/producer view plus stall controls exchanged with the hazard controller.
interface hazard_stall_ctrl_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_STAT     = 16
);
    logic                   i_valid;
    logic                   i_flush;
    logic [NB_REG_ADDR-1:0] i_id_rs;
    logic [NB_REG_ADDR-1:0] i_id_rt;
    logic                   i_id_use_rs;
    logic                   i_id_use_rt;
    logic                   i_id_branch;
    logic [NB_REG_ADDR-1:0] i_ex_rd;
    logic                   i_ex_we;
    logic                   i_ex_load;
    logic [NB_REG_ADDR-1:0] i_mem_rd;
    logic                   i_mem_load;
    logic                   o_stall;
    logic                   o_bubble;
    logic [1:0]             o_haz_type;
    logic [NB_STAT-1:0]     o_stall_cnt;

    modport master (
        output i_valid, i_flush, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_branch,
               i_ex_rd, i_ex_we, i_ex_load, i_mem_rd, i_mem_load,
        input  o_stall, o_bubble, o_haz_type, o_stall_cnt
    );

    modport slave (
        input  i_valid, i_flush, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_branch,
               i_ex_rd, i_ex_we, i_ex_load, i_mem_rd, i_mem_load,
        output o_stall, o_bubble, o_haz_type, o_stall_cnt
    );

endinterface

// File: rtl/hazard_stall_ctrl_reg_match_cmp.sv
// One source/destination register comparison; $0 is hardwired and never produces a hazard.
module hazard_stall_ctrl_reg_match_cmp #(
    parameter int NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] i_src,
    input  logic [NB_REG_ADDR-1:0] i_dst,
    input  logic                   i_use,
    input  logic                   i_wr,
    output logic                   o_match
);
    assign o_match = (i_src == i_dst) && i_use && i_wr && (i_dst != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand hazard controller: picks the longest required stall and runs a counted stall.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int NB_REG_ADDR     = 5,
    parameter int NB_CNT          = 2,
    parameter int LOAD_USE_STALLS = 1,
    parameter int BR_ALU_STALLS   = 1,
    parameter int BR_LOAD_STALLS  = 2,
    parameter int BR_MEMLD_STALLS = 1,
    parameter int NB_STAT         = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [NB_CNT-1:0] LU_N   = NB_CNT'(LOAD_USE_STALLS);
    localparam logic [NB_CNT-1:0] BRA_N  = NB_CNT'(BR_ALU_STALLS);
    localparam logic [NB_CNT-1:0] BRL_N  = NB_CNT'(BR_LOAD_STALLS);
    localparam logic [NB_CNT-1:0] BRM_N  = NB_CNT'(BR_MEMLD_STALLS);
    localparam logic [NB_CNT-1:0] CNT_1  = NB_CNT'(1);

    logic [NUM_CMP-1:0][NB_REG_ADDR-1:0] cmp_src, cmp_dst;
    logic [NUM_CMP-1:0]                  cmp_use, cmp_wr, cmp_hit;

    assign cmp_src = {bus.i_id_rt, bus.i_id_rs, bus.i_id_rt, bus.i_id_rs, bus.i_id_rt, bus.i_id_rs};
    assign cmp_dst = {bus.i_mem_rd, bus.i_mem_rd, bus.i_ex_rd, bus.i_ex_rd, bus.i_ex_rd, bus.i_ex_rd};
    assign cmp_use = {bus.i_id_use_rt, bus.i_id_use_rs, bus.i_id_use_rt, bus.i_id_use_rs,
                      bus.i_id_use_rt, bus.i_id_use_rs};
    assign cmp_wr  = {bus.i_mem_load, bus.i_mem_load, bus.i_ex_we, bus.i_ex_we,
                      bus.i_ex_load, bus.i_ex_load};

    genvar g;
    generate
        for (g = 0; g < NUM_CMP; g++) begin : g_cmp
            hazard_stall_ctrl_reg_match_cmp #(.NB_REG_ADDR(NB_REG_ADDR)) u_cmp (
                .i_src   (cmp_src[g]),
                .i_dst   (cmp_dst[g]),
                .i_use   (cmp_use[g]),
                .i_wr    (cmp_wr[g]),
                .o_match (cmp_hit[g])
            );
        end
    endgenerate

    logic ex_ld_hit, ex_we_hit, mem_ld_hit;
    assign ex_ld_hit  = |cmp_hit[CMP_EXLD+1:CMP_EXLD];
    assign ex_we_hit  = |cmp_hit[CMP_EXWE+1:CMP_EXWE];
    assign mem_ld_hit = |cmp_hit[CMP_MEMLD+1:CMP_MEMLD];

    logic [NB_CNT-1:0] need;
    haz_type_e         det_type;

    // Classes evaluated in ascending code order so that >= hands ties to the higher code.
    always_comb begin
        need     = '0;
        det_type = HAZ_NONE;
        if (ex_ld_hit && LU_N != '0) begin
            need     = LU_N;
            det_type = HAZ_LOADUSE;
        end
        if (bus.i_id_branch && ex_we_hit && !bus.i_ex_load && BRA_N != '0 && BRA_N >= need) begin
            need     = BRA_N;
            det_type = HAZ_BRALU;
        end
        if (bus.i_id_branch && mem_ld_hit && BRM_N != '0 && BRM_N >= need) begin
            need     = BRM_N;
            det_type = HAZ_BRLOAD;
        end
        if (bus.i_id_branch && ex_ld_hit && BRL_N != '0 && BRL_N >= need) begin
            need     = BRL_N;
            det_type = HAZ_BRLOAD;
        end
    end

    state_e             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    haz_type_e          type_q, type_d;
    logic [NB_STAT-1:0] stat_q, stat_d;
    logic               stall;
    haz_type_e          haz_type;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        stat_d   = stat_q;
        stall    = 1'b0;
        haz_type = HAZ_NONE;

        if (i_reset && !bus.i_flush) begin
            if (state_q == ST_STALL) begin
                stall    = 1'b1;
                haz_type = type_q;
            end else if (need != '0) begin
                stall    = 1'b1;
                haz_type = det_type;
            end
        end

        if (bus.i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bus.i_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (need > CNT_1) begin
                        state_d = ST_STALL;
                        cnt_d   = need - CNT_1;
                        type_d  = det_type;
                    end
                end
                ST_STALL: begin
                    if (cnt_q <= CNT_1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (bus.i_valid && stall && stat_q != '1)
            stat_d = stat_q + NB_STAT'(1);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            type_q  <= HAZ_NONE;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            stat_q  <= stat_d;
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_bubble    = stall;
    assign bus.o_haz_type  = haz_type;
    assign bus.o_stall_cnt = stat_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Drives a default controller and a BR_LOAD_STALLS=3 / NB_STAT=4 controller with identical stimulus.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, valid, flush, use_rs, use_rt, branch, ex_we, ex_load, mem_load;
    logic [4:0] rs, rt, ex_rd, mem_rd;

    hazard_stall_ctrl_if #(.NB_REG_ADDR(5), .NB_STAT(16)) ifa ();
    hazard_stall_ctrl_if #(.NB_REG_ADDR(5), .NB_STAT(4))  ifb ();

    hazard_stall_ctrl #(.NB_REG_ADDR(5), .NB_CNT(2), .LOAD_USE_STALLS(1), .BR_ALU_STALLS(1),
                        .BR_LOAD_STALLS(2), .BR_MEMLD_STALLS(1), .NB_STAT(16))
        dut_a (.i_clock(clk), .i_reset(rst_n), .bus(ifa));

    hazard_stall_ctrl #(.NB_REG_ADDR(5), .NB_CNT(2), .LOAD_USE_STALLS(1), .BR_ALU_STALLS(1),
                        .BR_LOAD_STALLS(3), .BR_MEMLD_STALLS(1), .NB_STAT(4))
        dut_b (.i_clock(clk), .i_reset(rst_n), .bus(ifb));

    int n_chk = 0;
    int n_err = 0;

    // Reference state: stalled cycles still owed after this one, held class, statistic.
    int m_rem[2], m_held[2], m_stat[2], exp_st[2];
    int brl[2]  = '{2, 3};
    int smax[2] = '{65535, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mt(int s, int d, bit u, bit w);
        return u && w && (s == d) && (d != 0);
    endfunction

    // Score = stalls*4 + code; the largest score wins, so ties pick the higher code.
    task automatic model_need(input int d, output int need, output int typ);
        int best = 0;
        bit exld  = mt(int'(rs), int'(ex_rd), use_rs, ex_load) || mt(int'(rt), int'(ex_rd), use_rt, ex_load);
        bit exwe  = mt(int'(rs), int'(ex_rd), use_rs, ex_we)   || mt(int'(rt), int'(ex_rd), use_rt, ex_we);
        bit memld = mt(int'(rs), int'(mem_rd), use_rs, mem_load) || mt(int'(rt), int'(mem_rd), use_rt, mem_load);
        if (exld && best < 1*4+1) best = 1*4+1;
        if (branch && exwe && !ex_load && best < 1*4+2) best = 1*4+2;
        if (branch && memld && best < 1*4+3) best = 1*4+3;
        if (branch && exld && best < brl[d]*4+3) best = brl[d]*4+3;
        need = best / 4;
        typ  = (need > 0) ? best % 4 : 0;
    endtask

    task automatic drive();
        ifa.i_valid = valid;     ifb.i_valid = valid;
        ifa.i_flush = flush;     ifb.i_flush = flush;
        ifa.i_id_rs = rs;        ifb.i_id_rs = rs;
        ifa.i_id_rt = rt;        ifb.i_id_rt = rt;
        ifa.i_id_use_rs = use_rs; ifb.i_id_use_rs = use_rs;
        ifa.i_id_use_rt = use_rt; ifb.i_id_use_rt = use_rt;
        ifa.i_id_branch = branch; ifb.i_id_branch = branch;
        ifa.i_ex_rd = ex_rd;     ifb.i_ex_rd = ex_rd;
        ifa.i_ex_we = ex_we;     ifb.i_ex_we = ex_we;
        ifa.i_ex_load = ex_load; ifb.i_ex_load = ex_load;
        ifa.i_mem_rd = mem_rd;   ifb.i_mem_rd = mem_rd;
        ifa.i_mem_load = mem_load; ifb.i_mem_load = mem_load;
    endtask

    task automatic clr();
        rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0; branch = 1'b0;
        ex_rd = '0; ex_we = 1'b0; ex_load = 1'b0; mem_rd = '0; mem_load = 1'b0;
        valid = 1'b1; flush = 1'b0; rst_n = 1'b1;
    endtask

    task automatic peek();
        drive();
        #1;
    endtask

    task automatic tick();
        int need, typ, st, ot;
        drive();
        #1;
        for (int d = 0; d < 2; d++) begin
            model_need(d, need, typ);
            if (!rst_n || flush) begin st = 0; ot = 0; end
            else if (m_rem[d] > 0) begin st = 1; ot = m_held[d]; end
            else begin st = (need > 0) ? 1 : 0; ot = typ; end
            exp_st[d] = st;
            if (d == 0) begin
                chk("a_stall",  32'(ifa.o_stall),     32'(st));
                chk("a_bubble", 32'(ifa.o_bubble),    32'(st));
                chk("a_type",   32'(ifa.o_haz_type),  32'(ot));
                chk("a_stat",   32'(ifa.o_stall_cnt), 32'(m_stat[0]));
            end else begin
                chk("b_stall",  32'(ifb.o_stall),     32'(st));
                chk("b_bubble", 32'(ifb.o_bubble),    32'(st));
                chk("b_type",   32'(ifb.o_haz_type),  32'(ot));
                chk("b_stat",   32'(ifb.o_stall_cnt), 32'(m_stat[1]));
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            model_need(d, need, typ);
            if (!rst_n) begin
                m_rem[d] = 0; m_stat[d] = 0;
            end else begin
                if (valid && exp_st[d] == 1 && m_stat[d] < smax[d]) m_stat[d]++;
                if (flush) m_rem[d] = 0;
                else if (valid) begin
                    if (m_rem[d] > 0) m_rem[d]--;
                    else if (need > 0) begin m_rem[d] = need - 1; m_held[d] = typ; end
                end
            end
        end
        #1;
    endtask

    task automatic set_brload();
        clr();
        ex_rd = 5'd7; ex_load = 1'b1; ex_we = 1'b1; rt = 5'd7; use_rt = 1'b1; branch = 1'b1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        drive();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin m_rem[d] = 0; m_held[d] = 0; m_stat[d] = 0; end

        // reset held with a live hazard on the inputs
        clr(); rst_n = 1'b0; ex_rd = 5'd5; ex_load = 1'b1; ex_we = 1'b1; rs = 5'd5; use_rs = 1'b1;
        peek();
        chk("rst_stall", 32'(ifa.o_stall), 32'd0);
        chk("rst_stat",  32'(ifa.o_stall_cnt), 32'd0);
        tick();

        // load-use: one stall cycle, type 1
        rst_n = 1'b1;
        peek();
        chk("lu_stall",  32'(ifa.o_stall),    32'd1);
        chk("lu_bubble", 32'(ifa.o_bubble),   32'd1);
        chk("lu_type",   32'(ifa.o_haz_type), 32'd1);
        tick();
        clr(); peek();
        chk("lu_done", 32'(ifa.o_stall), 32'd0);
        tick();

        // $0 never hazards
        clr(); ex_load = 1'b1; ex_we = 1'b1; use_rs = 1'b1;
        peek();
        chk("r0_stall", 32'(ifa.o_stall), 32'd0);
        tick();

        // branch on an EX load: 2 cycles on A, 3 on B
        set_brload(); peek();
        chk("bl_c1_stall", 32'(ifa.o_stall),    32'd1);
        chk("bl_c1_type",  32'(ifa.o_haz_type), 32'd3);
        tick();
        clr(); rt = 5'd7; use_rt = 1'b1; branch = 1'b1; mem_rd = 5'd7; mem_load = 1'b1;
        peek();
        chk("bl_c2_stall", 32'(ifa.o_stall),    32'd1);
        chk("bl_c2_type",  32'(ifa.o_haz_type), 32'd3);
        tick();
        clr(); rt = 5'd7; use_rt = 1'b1; branch = 1'b1;
        peek();
        chk("bl_c3_a", 32'(ifa.o_stall), 32'd0);
        chk("bl_c3_b", 32'(ifb.o_stall), 32'd1);
        tick();
        clr(); tick();

        // jr on an EX ALU result, then the same without reading rs
        clr(); ex_rd = 5'd3; ex_we = 1'b1; rs = 5'd3; use_rs = 1'b1; branch = 1'b1;
        peek();
        chk("jr_stall", 32'(ifa.o_stall),    32'd1);
        chk("jr_type",  32'(ifa.o_haz_type), 32'd2);
        tick();
        use_rs = 1'b0; peek();
        chk("jr_nouse", 32'(ifa.o_stall), 32'd0);
        tick();

        // freeze mid-stall
        set_brload(); tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("frz_hold", 32'(ifa.o_stall), 32'd1);
            tick();
        end
        valid = 1'b1; peek();
        chk("frz_last", 32'(ifa.o_stall), 32'd1);
        tick();
        clr(); peek();
        chk("frz_end", 32'(ifa.o_stall), 32'd0);
        tick();
        clr(); tick(); tick();

        // flush mid-stall
        set_brload(); tick();
        flush = 1'b1; peek();
        chk("fl_stall", 32'(ifa.o_stall),    32'd0);
        chk("fl_type",  32'(ifa.o_haz_type), 32'd0);
        tick();
        clr(); peek();
        chk("fl_idle", 32'(ifa.o_stall), 32'd0);
        tick();

        // reset mid-stall
        set_brload(); tick();
        rst_n = 1'b0; peek();
        chk("rs_stall", 32'(ifa.o_stall), 32'd0);
        tick();
        clr(); peek();
        chk("rs_stat", 32'(ifa.o_stall_cnt), 32'd0);
        chk("rs_idle", 32'(ifa.o_stall),     32'd0);
        tick();

        // continuous load-use hazard saturates the 4-bit statistic
        clr(); ex_rd = 5'd9; ex_load = 1'b1; ex_we = 1'b1; rs = 5'd9; use_rs = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        peek();
        chk("sat_b", 32'(ifb.o_stall_cnt), 32'd15);
        tick();

        // randomized traffic over a small register window to provoke matches
        for (int i = 0; i < 1500; i++) begin
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            mem_rd   = 5'($urandom_range(0, 3));
            use_rs   = 1'($urandom_range(0, 1));
            use_rt   = 1'($urandom_range(0, 1));
            branch   = 1'($urandom_range(0, 1));
            ex_we    = 1'($urandom_range(0, 1));
            ex_load  = 1'($urandom_range(0, 1));
            mem_load = 1'($urandom_range(0, 1));
            valid    = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            rst_n    = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
